// File: rtl/mdr_mem_interface.sv
// Memory Data Register with a handshaked memory read/write port.
// Optional wait-state timeout abort is compiled in with `define MDR_TIMEOUT_EN.
module mdr_mem_interface #(
  parameter int unsigned TIMEOUT_CYCLES = 16
) (
  input  logic        clock,
  input  logic        clear,
  input  logic [31:0] BusMuxOut,
  input  logic        MDRin,
  input  logic        Read,
  input  logic        Write,
  input  logic [31:0] mem_data_in,
  input  logic        mem_ack,
  output logic        mem_rd_req,
  output logic        mem_wr_req,
  output logic [31:0] mem_data_out,
  output logic [31:0] BusMuxIn_MDR,
  output logic        busy,
  output logic        timeout_err
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_RD_WAIT = 2'd1;
  localparam logic [1:0] S_WR_WAIT = 2'd2;

`ifdef MDR_TIMEOUT_EN
  localparam logic TMO_EN = 1'b1;
`else
  localparam logic TMO_EN = 1'b0;
`endif

  logic [1:0]  r_state;
  logic [31:0] r_mdr;
  logic        r_rd_req;
  logic        r_wr_req;
  logic        r_busy;
  logic        r_tmo;
  logic [7:0]  r_cnt;

  logic        w_rd_start;
  logic        w_tmo_hit;

  assign w_rd_start = MDRin && Read;
  assign w_tmo_hit  = TMO_EN && (r_cnt == 8'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clock) begin
    if (clear) begin
      r_state  <= S_IDLE;
      r_mdr    <= '0;
      r_rd_req <= 1'b0;
      r_wr_req <= 1'b0;
      r_busy   <= 1'b0;
      r_tmo    <= 1'b0;
      r_cnt    <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_cnt <= '0;
          // Read start has priority and suppresses a simultaneous Write.
          if (w_rd_start) begin
            r_rd_req <= 1'b1;
            r_busy   <= 1'b1;
            r_state  <= S_RD_WAIT;
          end else begin
            if (MDRin) r_mdr <= BusMuxOut;
            if (Write) begin
              r_wr_req <= 1'b1;
              r_busy   <= 1'b1;
              r_state  <= S_WR_WAIT;
            end
          end
        end
        S_RD_WAIT, S_WR_WAIT: begin
          if (mem_ack) begin
            if (r_state == S_RD_WAIT) r_mdr <= mem_data_in;
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end else if (w_tmo_hit) begin
            r_rd_req <= 1'b0;
            r_wr_req <= 1'b0;
            r_busy   <= 1'b0;
            r_tmo    <= 1'b1;
            r_cnt    <= '0;
            r_state  <= S_IDLE;
          end else if (r_cnt != 8'hFF) begin
            r_cnt <= r_cnt + 8'd1;
          end
        end
        default: begin
          r_state  <= S_IDLE;
          r_rd_req <= 1'b0;
          r_wr_req <= 1'b0;
          r_busy   <= 1'b0;
          r_cnt    <= '0;
        end
      endcase
    end
  end

  assign mem_rd_req   = r_rd_req;
  assign mem_wr_req   = r_wr_req;
  assign mem_data_out = r_mdr;
  assign BusMuxIn_MDR = r_mdr;
  assign busy         = r_busy;
  assign timeout_err  = r_tmo;

endmodule

// File: tb/tb_mdr_mem_interface.sv
// Self-checking bench for mdr_mem_interface: vector table plus timeout/persistence sequences.
module tb_mdr_mem_interface;

  localparam int unsigned TMO = 4;

  logic        clock = 1'b0;
  logic        clear;
  logic [31:0] BusMuxOut;
  logic        MDRin;
  logic        Read;
  logic        Write;
  logic [31:0] mem_data_in;
  logic        mem_ack;
  logic        mem_rd_req;
  logic        mem_wr_req;
  logic [31:0] mem_data_out;
  logic [31:0] BusMuxIn_MDR;
  logic        busy;
  logic        timeout_err;

  int checks = 0;
  int errors = 0;

  mdr_mem_interface #(.TIMEOUT_CYCLES(TMO)) dut (
    .clock        (clock),
    .clear        (clear),
    .BusMuxOut    (BusMuxOut),
    .MDRin        (MDRin),
    .Read         (Read),
    .Write        (Write),
    .mem_data_in  (mem_data_in),
    .mem_ack      (mem_ack),
    .mem_rd_req   (mem_rd_req),
    .mem_wr_req   (mem_wr_req),
    .mem_data_out (mem_data_out),
    .BusMuxIn_MDR (BusMuxIn_MDR),
    .busy         (busy),
    .timeout_err  (timeout_err)
  );

  always #5 clock = ~clock;

  typedef struct {
    logic        clr;
    logic        mdrin;
    logic        rd;
    logic        wr;
    logic [31:0] bus;
    logic        ack;
    logic [31:0] din;
    logic [31:0] e_mdr;
    logic        e_rd;
    logic        e_wr;
    logic        e_busy;
    logic        e_tmo;
  } vec_t;

  typedef struct {
    logic [31:0] mdr;
    logic        rd;
    logic        wr;
    logic        busy;
    logic        tmo;
  } exp_t;

  exp_t exp_q[$];
  vec_t vecs[20];

  function automatic vec_t mk(logic clr, logic mdrin, logic rd, logic wr, logic [31:0] bus,
                              logic ack, logic [31:0] din, logic [31:0] e_mdr,
                              logic e_rd, logic e_wr, logic e_busy, logic e_tmo);
    vec_t v;
    v.clr = clr; v.mdrin = mdrin; v.rd = rd; v.wr = wr; v.bus = bus;
    v.ack = ack; v.din = din; v.e_mdr = e_mdr; v.e_rd = e_rd; v.e_wr = e_wr;
    v.e_busy = e_busy; v.e_tmo = e_tmo;
    return v;
  endfunction

  task automatic cmp(string name, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // Drive one cycle at negedge, queue its expectation, and compare #1 after the edge.
  task automatic step(logic clr, logic mdrin, logic rd, logic wr, logic [31:0] bus,
                      logic ack, logic [31:0] din, exp_t e);
    exp_t got;
    @(negedge clock);
    clear = clr; MDRin = mdrin; Read = rd; Write = wr; BusMuxOut = bus;
    mem_ack = ack; mem_data_in = din;
    exp_q.push_back(e);
    @(posedge clock);
    #1;
    if (exp_q.size() == 0) begin
      checks++; errors++;
      $display("FAIL scoreboard: queue empty");
    end else begin
      got = exp_q.pop_front();
      cmp("mdr",         BusMuxIn_MDR, got.mdr);
      cmp("mem_data_out", mem_data_out, got.mdr);
      cmp("mem_rd_req",  {31'b0, mem_rd_req}, {31'b0, got.rd});
      cmp("mem_wr_req",  {31'b0, mem_wr_req}, {31'b0, got.wr});
      cmp("busy",        {31'b0, busy}, {31'b0, got.busy});
      cmp("timeout_err", {31'b0, timeout_err}, {31'b0, got.tmo});
    end
  endtask

  function automatic exp_t ex(logic [31:0] mdr, logic rd, logic wr, logic bsy, logic tmo);
    exp_t e;
    e.mdr = mdr; e.rd = rd; e.wr = wr; e.busy = bsy; e.tmo = tmo;
    return e;
  endfunction

  initial begin
    logic tmo_en;
`ifdef MDR_TIMEOUT_EN
    tmo_en = 1'b1;
`else
    tmo_en = 1'b0;
`endif
    clear = 1'b1; MDRin = 1'b0; Read = 1'b0; Write = 1'b0;
    BusMuxOut = '0; mem_ack = 1'b0; mem_data_in = '0;

    //            clr md rd wr bus           ack din           e_mdr         rd wr bsy tmo
    vecs[0]  = mk(1, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         0, 0, 0, 0);
    vecs[1]  = mk(0, 1, 0, 0, 32'h0000_0008, 0, 32'h0,         32'h0000_0008, 0, 0, 0, 0);
    vecs[2]  = mk(0, 0, 0, 0, 32'h0,         1, 32'hDEAD_BEEF, 32'h0000_0008, 0, 0, 0, 0);
    vecs[3]  = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'h0000_0008, 1, 0, 1, 0);
    vecs[4]  = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0000_0008, 1, 0, 1, 0);
    vecs[5]  = mk(0, 1, 0, 1, 32'h1234_5678, 0, 32'h0,         32'h0000_0008, 1, 0, 1, 0);
    vecs[6]  = mk(0, 0, 0, 0, 32'h0,         1, 32'h0040_0000, 32'h0040_0000, 0, 0, 0, 0);
    vecs[7]  = mk(0, 1, 0, 0, 32'h0001_0000, 0, 32'h0,         32'h0001_0000, 0, 0, 0, 0);
    vecs[8]  = mk(0, 0, 0, 1, 32'h0,         0, 32'h0,         32'h0001_0000, 0, 1, 1, 0);
    vecs[9]  = mk(0, 1, 0, 0, 32'hFFFF_FFFF, 0, 32'h0,         32'h0001_0000, 0, 1, 1, 0);
    vecs[10] = mk(0, 1, 1, 1, 32'h0,         0, 32'h0,         32'h0001_0000, 0, 1, 1, 0);
    vecs[11] = mk(0, 0, 0, 0, 32'h0,         1, 32'hAAAA_AAAA, 32'h0001_0000, 0, 0, 0, 0);
    vecs[12] = mk(0, 1, 1, 1, 32'h0,         0, 32'h0,         32'h0001_0000, 1, 0, 1, 0);
    vecs[13] = mk(0, 0, 0, 0, 32'h0,         1, 32'hCAFE_F00D, 32'hCAFE_F00D, 0, 0, 0, 0);
    vecs[14] = mk(0, 1, 0, 1, 32'h1357_9BDF, 0, 32'h0,         32'h1357_9BDF, 0, 1, 1, 0);
    vecs[15] = mk(0, 0, 0, 0, 32'h0,         1, 32'h5555_5555, 32'h1357_9BDF, 0, 0, 0, 0);
    vecs[16] = mk(0, 1, 1, 0, 32'h0,         0, 32'h0,         32'h1357_9BDF, 1, 0, 1, 0);
    vecs[17] = mk(1, 1, 0, 1, 32'h7777_7777, 1, 32'h9999_9999, 32'h0,         0, 0, 0, 0);
    vecs[18] = mk(0, 0, 0, 0, 32'h0,         1, 32'hFFFF_FFFF, 32'h0,         0, 0, 0, 0);
    vecs[19] = mk(0, 0, 0, 0, 32'h0,         0, 32'h0,         32'h0,         0, 0, 0, 0);

    for (int i = 0; i < 20; i++)
      step(vecs[i].clr, vecs[i].mdrin, vecs[i].rd, vecs[i].wr, vecs[i].bus,
           vecs[i].ack, vecs[i].din,
           ex(vecs[i].e_mdr, vecs[i].e_rd, vecs[i].e_wr, vecs[i].e_busy, vecs[i].e_tmo));

    // Read with no ack: aborts after TMO wait cycles when enabled, else persists.
    step(0, 1, 0, 0, 32'h0000_00A5, 0, 0, ex(32'h0000_00A5, 0, 0, 0, 0));
    step(0, 1, 1, 0, 0, 0, 0, ex(32'h0000_00A5, 1, 0, 1, 0));
    for (int k = 1; k < 12; k++) begin
      if (tmo_en && k >= int'(TMO))
        step(0, 0, 0, 0, 0, 0, 32'h1111_1111, ex(32'h0000_00A5, 0, 0, 0, 1));
      else
        step(0, 0, 0, 0, 0, 0, 32'h1111_1111, ex(32'h0000_00A5, 1, 0, 1, 0));
    end
    if (!tmo_en)
      step(0, 0, 0, 0, 0, 1, 32'h2222_2222, ex(32'h2222_2222, 0, 0, 0, 0));
    step(1, 0, 0, 0, 0, 0, 0, ex(32'h0, 0, 0, 0, 0));

    // Write with no ack: same abort/persist behaviour, MDR never changes.
    step(0, 1, 0, 1, 32'h0BAD_CAFE, 0, 0, ex(32'h0BAD_CAFE, 0, 1, 1, 0));
    for (int k = 1; k < 8; k++) begin
      if (tmo_en && k >= int'(TMO))
        step(0, 0, 0, 0, 0, 0, 0, ex(32'h0BAD_CAFE, 0, 0, 0, 1));
      else
        step(0, 0, 0, 0, 0, 0, 0, ex(32'h0BAD_CAFE, 0, 1, 1, 0));
    end
    if (!tmo_en)
      step(0, 0, 0, 0, 0, 1, 0, ex(32'h0BAD_CAFE, 0, 0, 0, 0));
    step(1, 0, 0, 0, 0, 0, 0, ex(32'h0, 0, 0, 0, 0));

    // Ack arriving on the last allowed wait cycle completes normally.
    step(0, 1, 1, 0, 0, 0, 0, ex(32'h0, 1, 0, 1, 0));
    for (int k = 1; k < int'(TMO); k++)
      step(0, 0, 0, 0, 0, 0, 0, ex(32'h0, 1, 0, 1, 0));
    step(0, 0, 0, 0, 0, 1, 32'h0BEE_F123, ex(32'h0BEE_F123, 0, 0, 0, 0));
    step(0, 0, 0, 0, 0, 0, 0, ex(32'h0BEE_F123, 0, 0, 0, 0));

    if (exp_q.size() != 0) begin
      checks++; errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", exp_q.size());
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/mdr_mem_interface.md
MDR_MEM_INTERFACE -- requirements
Module: mdr_mem_interface

Interface
REQ-001 SHALL have parameter TIMEOUT_CYCLES, default 16, giving the number of wait-state cycles before a memory transaction is aborted (range 2..255).
REQ-002 SHALL have port clock  input  1  the single clock; all state changes on its rising edge.
REQ-003 SHALL have port clear  input  1  reset, synchronous and active-high.
REQ-004 SHALL have port BusMuxOut  input  32  datapath bus value, sourced by the 32:1 bus multiplexer.
REQ-005 SHALL have port MDRin  input  1  MDR load strobe.
REQ-006 SHALL have port Read  input  1  MDR source select: 1 = memory read, 0 = bus.
REQ-007 SHALL have port Write  input  1  write strobe: start a memory write of the current MDR value.
REQ-008 SHALL have port mem_data_in  input  32  read data from memory, valid when mem_ack=1.
REQ-009 SHALL have port mem_ack  input  1  memory completion acknowledge.
REQ-010 SHALL have port mem_rd_req  output  1  memory read request.
REQ-011 SHALL have port mem_wr_req  output  1  memory write request.
REQ-012 SHALL have port mem_data_out  output  32  write data to memory (equals MDR).
REQ-013 SHALL have port BusMuxIn_MDR  output  32  MDR contents, fed to the bus multiplexer MDR input.
REQ-014 SHALL have port busy  output  1  high while a memory transaction is outstanding.
REQ-015 SHALL have port timeout_err  output  1  sticky flag: a transaction was aborted by timeout.

Function
REQ-016 SHALL implement FSM states IDLE, RD_WAIT and WR_WAIT, all outputs registered.
REQ-017 In IDLE with MDRin=1, Read=0: MDR SHALL load BusMuxOut at the edge; BusMuxIn_MDR updates 1 cycle after the strobe; state remains IDLE.
REQ-018 In IDLE with MDRin=1, Read=1: the edge SHALL set mem_rd_req=1 and enter RD_WAIT.
REQ-019 In IDLE with Write=1 and no read start: the edge SHALL set mem_wr_req=1 and enter WR_WAIT; mem_data_out SHALL equal MDR at all times.
REQ-020 Simultaneous read start and Write in IDLE: read SHALL win; the Write is dropped.
REQ-021 Simultaneous MDRin(Read=0) and Write in IDLE: MDR SHALL load BusMuxOut, and the write SHALL carry the newly loaded value.
REQ-022 In RD_WAIT with mem_ack=1: the edge SHALL load mem_data_in into MDR, clear mem_rd_req and return to IDLE.
REQ-023 In WR_WAIT with mem_ack=1: the edge SHALL clear mem_wr_req and return to IDLE; MDR unchanged.
REQ-024 busy SHALL equal (state != IDLE); MDRin, Read and Write SHALL be ignored while busy.
REQ-025 mem_ack in IDLE SHALL be ignored.
REQ-026 The wait counter SHALL zero on entry to a wait state and increment each wait cycle without ack.
REQ-027 A round trip SHALL be: strobe at edge N, request high from N, ack sampled at edge M, MDR valid and busy low from M.

Reset
REQ-028 clear=1 at an edge SHALL force IDLE, MDR=0, mem_rd_req=0, mem_wr_req=0, busy=0, timeout_err=0 and counter=0, including mid-transaction; clear SHALL dominate all other inputs.

Configuration
REQ-029 Macro MDR_TIMEOUT_EN defined: when the counter reaches TIMEOUT_CYCLES-1 with mem_ack=0, the next edge SHALL drop the request, return to IDLE, leave MDR unchanged and set timeout_err until clear; an ack at that same edge SHALL take priority as a normal completion.
REQ-030 MDR_TIMEOUT_EN undefined: wait states SHALL persist until mem_ack or clear, with timeout_err tied to 0.

Verification
REQ-031 BusMuxOut=32'h0000_0008, MDRin=1, Read=0 for 1 cycle -> BusMuxIn_MDR=32'h0000_0008 next cycle, busy stays 0.
REQ-032 MDRin=1, Read=1 -> mem_rd_req=1, busy=1; ack after 3 cycles with mem_data_in=32'h0040_0000 -> BusMuxIn_MDR=32'h0040_0000, busy=0, mem_rd_req=0.
REQ-033 MDR=32'h0001_0000, Write=1 -> mem_wr_req=1, mem_data_out=32'h0001_0000; ack -> mem_wr_req=0; MDRin pulse while busy -> MDR unchanged.
REQ-034 Read start and Write in the same cycle -> only mem_rd_req asserts; mem_wr_req stays 0 throughout.
REQ-035 With MDR_TIMEOUT_EN, TIMEOUT_CYCLES=4, read with no ack -> busy falls after 4 wait cycles, timeout_err=1, MDR unchanged; ack on the 4th wait cycle -> timeout_err stays 0 and MDR loads.
REQ-036 clear during RD_WAIT -> next cycle IDLE with all outputs 0; a later mem_ack=1 is ignored.
